// File: rtl/mem_access_stage_pkg.sv
// Shared types for the memory stage: FSM states, lane index, byte enables.
// Optional feature macro: MEM_TIMEOUT_EN (used by mem_access_stage).
package mem_access_stage_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } mstate_t;

  localparam logic [3:0] BE_WORD = 4'b1111;

  typedef logic [1:0] lane_t;
endpackage

// File: rtl/mem_access_stage_lane_steer.sv
// Byte-lane steering: byte enables, store replication, load byte extract.
// Purely combinational; lane 0 is bits 7:0.
module mem_lane_steer
  import mem_access_stage_pkg::*;
(
  input  logic        byte_sel,
  input  lane_t       lane,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_lanes,
  output logic [31:0] rdata_ext
);
  always_comb begin
    be          = BE_WORD;
    wdata_lanes = wdata;
    rdata_ext   = rdata;
    if (byte_sel) begin
      be          = 4'b0001 << lane;
      wdata_lanes = {4{wdata[7:0]}};
      rdata_ext   = {24'b0, rdata[8*lane +: 8]};
    end
  end
endmodule

// File: rtl/mem_access_stage.sv
// M stage: req/ack data-memory access with stall and WB bubble.
// Optional MEM_TIMEOUT_EN abandons a WAIT after TIMEOUT_CYCLES cycles.
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        PCSrcM,
  input  logic        RegWriteM,
  input  logic        MemtoRegM,
  input  logic        MemWriteM,
  input  logic        ByteM,
  input  logic [3:0]  RdM,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  output logic        PCSrcOut,
  output logic        RegWriteOut,
  output logic        MemtoRegOut,
  output logic [3:0]  RdOut,
  output logic [31:0] ALUResultOut,
  output logic [31:0] ReadDataM,
  output logic        StallM,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        mem_fault
);
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_tmo
    $error("TIMEOUT_CYCLES out of range");
  end

  mstate_t     state_q;
  logic        access;
  logic [3:0]  be_c;
  logic [31:0] wdata_c;
  logic [31:0] rdata_c;
  logic        we_q;
  logic [3:0]  be_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic        tmo_hit;
  logic        tmo_done;

  assign access = MemtoRegM | MemWriteM;

  mem_lane_steer u_steer (
    .byte_sel    (ByteM),
    .lane        (ALUResultM[1:0]),
    .wdata       (WriteDataM),
    .rdata       (dmem_rdata),
    .be          (be_c),
    .wdata_lanes (wdata_c),
    .rdata_ext   (rdata_c)
  );

`ifdef MEM_TIMEOUT_EN
  logic [15:0] cnt_q;
  logic        to_q;
  logic        fault_q;

  assign tmo_hit   = (state_q == WAIT) && !dmem_ack
                  && (cnt_q == 16'(TIMEOUT_CYCLES - 1));
  assign tmo_done  = to_q;
  assign mem_fault = fault_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q   <= '0;
      to_q    <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      if (state_q == IDLE) begin
        cnt_q <= '0;
        to_q  <= 1'b0;
      end else if (state_q == WAIT) begin
        cnt_q <= cnt_q + 16'd1;
      end
      if (tmo_hit) begin
        to_q    <= 1'b1;
        fault_q <= 1'b1;
      end
    end
  end
`else
  assign tmo_hit   = 1'b0;
  assign tmo_done  = 1'b0;
  assign mem_fault = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      be_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: if (access) begin
          state_q <= WAIT;
          we_q    <= MemWriteM;
          be_q    <= be_c;
          addr_q  <= {ALUResultM[31:2], 2'b00};
          wdata_q <= wdata_c;
          rdata_q <= '0;
        end
        WAIT: if (dmem_ack || tmo_hit) begin
          state_q <= DONE;
          we_q    <= 1'b0;
          be_q    <= '0;
          addr_q  <= '0;
          wdata_q <= '0;
          rdata_q <= (dmem_ack && MemtoRegM) ? rdata_c : '0;
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign dmem_req   = (state_q == WAIT);
  assign dmem_we    = we_q;
  assign dmem_be    = be_q;
  assign dmem_addr  = addr_q;
  assign dmem_wdata = wdata_q;

  assign StallM = ((state_q == IDLE) && access) || (state_q == WAIT);
  assign ReadDataM = (state_q == DONE) ? rdata_q : '0;

  // Bubble the control bits while stalled; data fields pass through.
  assign PCSrcOut     = PCSrcM & ~StallM;
  assign MemtoRegOut  = MemtoRegM & ~StallM;
  assign RegWriteOut  = RegWriteM & ~StallM
                      & ~((state_q == DONE) & tmo_done);
  assign RdOut        = RdM;
  assign ALUResultOut = ALUResultM;
endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage with a transaction-level model.
// Timeout scenario is exercised when built with MEM_TIMEOUT_EN.
module tb_mem_access_stage;
  logic        clk = 1'b0;
  logic        reset;
  logic        PCSrcM, RegWriteM, MemtoRegM, MemWriteM, ByteM;
  logic [3:0]  RdM;
  logic [31:0] ALUResultM, WriteDataM;
  logic        PCSrcOut, RegWriteOut, MemtoRegOut;
  logic [3:0]  RdOut;
  logic [31:0] ALUResultOut, ReadDataM;
  logic        StallM;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        dmem_ack;
  logic        mem_fault;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_access_stage #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset(reset),
    .PCSrcM(PCSrcM), .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM),
    .MemWriteM(MemWriteM), .ByteM(ByteM), .RdM(RdM),
    .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
    .PCSrcOut(PCSrcOut), .RegWriteOut(RegWriteOut),
    .MemtoRegOut(MemtoRegOut), .RdOut(RdOut),
    .ALUResultOut(ALUResultOut), .ReadDataM(ReadDataM),
    .StallM(StallM), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack), .mem_fault(mem_fault)
  );

  task automatic set_nop();
    PCSrcM = 0; RegWriteM = 0; MemtoRegM = 0; MemWriteM = 0; ByteM = 0;
    RdM = 0; ALUResultM = 0; WriteDataM = 0;
  endtask

  function automatic logic [3:0] exp_be(bit b, logic [31:0] a);
    return b ? 4'(1 << a[1:0]) : 4'hF;
  endfunction

  function automatic logic [31:0] exp_wd(bit b, logic [31:0] d);
    return b ? {24'b0, d[7:0]} * 32'h0101_0101 : d;
  endfunction

  function automatic logic [31:0] exp_rd(bit ld, bit b, logic [31:0] a,
                                         logic [31:0] r);
    if (!ld) return 0;
    return b ? (r >> (8 * a[1:0])) & 32'hFF : r;
  endfunction

  // One access: issue cycle, lat WAIT cycles (ack in the last), DONE.
  task automatic do_access(input bit ld, input bit b, input logic [31:0] a,
                           input logic [31:0] wd, input logic [31:0] rd,
                           input int lat, input bit rw, input bit pc,
                           input logic [3:0] rdst, input string nm);
    PCSrcM = pc; RegWriteM = rw; MemtoRegM = ld; MemWriteM = !ld;
    ByteM = b; RdM = rdst; ALUResultM = a; WriteDataM = wd;
    @(negedge clk);
    n_checks++;
    if (StallM !== 1'b1 || dmem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL %s issue: stall=%b req=%b, want stall=1 req=0",
               nm, StallM, dmem_req);
    end
    @(posedge clk); #1;
    for (int w = 1; w <= lat; w++) begin
      dmem_rdata = $urandom;
      @(negedge clk);
      n_checks++;
      if (dmem_req !== 1'b1 || StallM !== 1'b1 || dmem_we !== !ld
          || dmem_addr !== {a[31:2], 2'b00} || dmem_be !== exp_be(b, a)
          || dmem_wdata !== exp_wd(b, wd)) begin
        n_fail++;
        $display("FAIL %s wait%0d: req=%b st=%b we=%b ad=%h be=%b wd=%h want we=%b ad=%h be=%b wd=%h",
                 nm, w, dmem_req, StallM, dmem_we, dmem_addr, dmem_be,
                 dmem_wdata, !ld, {a[31:2], 2'b00}, exp_be(b, a),
                 exp_wd(b, wd));
      end
      n_checks++;
      if (PCSrcOut !== 0 || RegWriteOut !== 0 || MemtoRegOut !== 0
          || RdOut !== rdst || ALUResultOut !== a || ReadDataM !== 0) begin
        n_fail++;
        $display("FAIL %s bubble%0d: pc=%b rw=%b m2r=%b rd=%h alu=%h rdata=%h",
                 nm, w, PCSrcOut, RegWriteOut, MemtoRegOut, RdOut,
                 ALUResultOut, ReadDataM);
      end
      if (w == lat) begin
        dmem_rdata = rd;
        dmem_ack = 1;
      end
      @(posedge clk); #1;
      dmem_ack = 0;
      dmem_rdata = $urandom;
    end
    @(negedge clk);
    n_checks++;
    if (StallM !== 0 || dmem_req !== 0 || RegWriteOut !== rw
        || PCSrcOut !== pc || MemtoRegOut !== ld
        || ReadDataM !== exp_rd(ld, b, a, rd)) begin
      n_fail++;
      $display("FAIL %s done: st=%b req=%b rw=%b pc=%b rdata=%h want rw=%b rdata=%h",
               nm, StallM, dmem_req, RegWriteOut, PCSrcOut, ReadDataM,
               rw, exp_rd(ld, b, a, rd));
    end
    @(posedge clk); #1;
    set_nop();
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_checks++;
    if (dmem_req !== 0 || dmem_we !== 0 || dmem_be !== 0 || dmem_addr !== 0
        || dmem_wdata !== 0 || ReadDataM !== 0 || mem_fault !== 0
        || StallM !== 0) begin
      n_fail++;
      $display("FAIL reset: req=%b we=%b be=%b ad=%h wd=%h rdata=%h flt=%b st=%b, want all 0",
               dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata, ReadDataM,
               mem_fault, StallM);
    end
    @(posedge clk); #1;
    reset = 0;
  endtask

  task automatic test_passthrough();
    for (int i = 0; i < 6; i++) begin
      logic [31:0] a;
      logic [3:0] r;
      logic p, w;
      a = (i == 0) ? 32'h10 : $urandom;
      r = 4'($urandom);
      p = (i == 0) ? 1'b0 : 1'($urandom);
      w = (i == 0) ? 1'b1 : 1'($urandom);
      PCSrcM = p; RegWriteM = w; MemtoRegM = 0; MemWriteM = 0;
      ByteM = 1'($urandom); RdM = r; ALUResultM = a; WriteDataM = $urandom;
      #1;
      n_checks++;
      if (StallM !== 0 || dmem_req !== 0 || ReadDataM !== 0
          || RegWriteOut !== w || PCSrcOut !== p || MemtoRegOut !== 0
          || RdOut !== r || ALUResultOut !== a) begin
        n_fail++;
        $display("FAIL pass%0d: st=%b req=%b rdata=%h rw=%b pc=%b rd=%h alu=%h",
                 i, StallM, dmem_req, ReadDataM, RegWriteOut, PCSrcOut,
                 RdOut, ALUResultOut);
      end
      @(posedge clk); #1;
    end
    set_nop();
  endtask

  task automatic test_directed();
    do_access(1, 0, 32'h100, 32'h0, 32'hCAFEBABE, 2, 1, 0, 4'd3, "ldr");
    do_access(0, 1, 32'h203, 32'h12345678, 32'h0, 1, 0, 0, 4'd0, "strb");
    do_access(1, 1, 32'h41, 32'h0, 32'hAABBCCDD, 1, 1, 0, 4'd5, "ldrb");
  endtask

  task automatic test_random();
    for (int i = 0; i < 24; i++) begin
      do_access(1'($urandom), 1'($urandom), $urandom, $urandom, $urandom,
                int'($urandom_range(1, 3)), 1'($urandom), 1'($urandom),
                4'($urandom), "rand");
    end
  endtask

  task automatic test_reset_mid_wait();
    PCSrcM = 0; RegWriteM = 1; MemtoRegM = 1; ByteM = 0;
    RdM = 4'd7; ALUResultM = 32'h300;
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++;
    if (dmem_req !== 1) begin
      n_fail++;
      $display("FAIL rstwait pre: req=%b, want 1", dmem_req);
    end
    #1;
    reset = 1;
    set_nop();
    #1;
    n_checks++;
    if (dmem_req !== 0 || dmem_be !== 0 || dmem_addr !== 0 || StallM !== 0
        || ReadDataM !== 0) begin
      n_fail++;
      $display("FAIL rstwait async: req=%b be=%b ad=%h st=%b rdata=%h, want 0",
               dmem_req, dmem_be, dmem_addr, StallM, ReadDataM);
    end
    @(negedge clk);
    reset = 0;
    @(posedge clk); #1;
    dmem_ack = 1; dmem_rdata = 32'hDEADBEEF;
    @(negedge clk);
    n_checks++;
    if (dmem_req !== 0 || StallM !== 0 || RegWriteOut !== 0) begin
      n_fail++;
      $display("FAIL rstwait ack: req=%b st=%b rw=%b, want 0",
               dmem_req, StallM, RegWriteOut);
    end
    @(posedge clk); #1;
    dmem_ack = 0;
    @(negedge clk);
    n_checks++;
    if (ReadDataM !== 0 || dmem_req !== 0) begin
      n_fail++;
      $display("FAIL rstwait after: rdata=%h req=%b, want 0",
               ReadDataM, dmem_req);
    end
    @(posedge clk); #1;
  endtask

`ifdef MEM_TIMEOUT_EN
  task automatic test_timeout();
    PCSrcM = 0; RegWriteM = 1; MemtoRegM = 1; ByteM = 0;
    RdM = 4'd9; ALUResultM = 32'h500;
    @(posedge clk); #1;
    for (int w = 1; w <= 4; w++) begin
      @(negedge clk);
      n_checks++;
      if (dmem_req !== 1 || StallM !== 1 || mem_fault !== 0) begin
        n_fail++;
        $display("FAIL tmo wait%0d: req=%b st=%b flt=%b", w, dmem_req,
                 StallM, mem_fault);
      end
      @(posedge clk); #1;
    end
    @(negedge clk);
    n_checks++;
    if (dmem_req !== 0 || StallM !== 0 || mem_fault !== 1
        || ReadDataM !== 0 || RegWriteOut !== 0) begin
      n_fail++;
      $display("FAIL tmo done: req=%b st=%b flt=%b rdata=%h rw=%b, want 0 0 1 0 0",
               dmem_req, StallM, mem_fault, ReadDataM, RegWriteOut);
    end
    @(posedge clk); #1;
    set_nop();
    do_access(1, 0, 32'h600, 32'h0, 32'h13572468, 1, 1, 0, 4'd2, "postmo");
    n_checks++;
    if (mem_fault !== 1) begin
      n_fail++;
      $display("FAIL tmo sticky: flt=%b, want 1", mem_fault);
    end
  endtask
`else
  task automatic test_timeout();
    PCSrcM = 0; RegWriteM = 1; MemtoRegM = 1; ByteM = 0;
    RdM = 4'd9; ALUResultM = 32'h500;
    @(posedge clk); #1;
    for (int w = 1; w <= 12; w++) begin
      @(negedge clk);
      n_checks++;
      if (dmem_req !== 1 || StallM !== 1 || mem_fault !== 0) begin
        n_fail++;
        $display("FAIL hold wait%0d: req=%b st=%b flt=%b", w, dmem_req,
                 StallM, mem_fault);
      end
      if (w == 12) begin
        dmem_ack = 1; dmem_rdata = 32'h0BADF00D;
      end
      @(posedge clk); #1;
      dmem_ack = 0;
    end
    @(negedge clk);
    n_checks++;
    if (ReadDataM !== 32'h0BADF00D || RegWriteOut !== 1 || StallM !== 0) begin
      n_fail++;
      $display("FAIL hold done: rdata=%h rw=%b st=%b, want 0badf00d 1 0",
               ReadDataM, RegWriteOut, StallM);
    end
    @(posedge clk); #1;
    set_nop();
  endtask
`endif

  initial begin
    reset = 1;
    dmem_ack = 0;
    dmem_rdata = 0;
    set_nop();
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_passthrough();
    test_directed();
    test_random();
    test_reset_mid_wait();
    test_passthrough();
    test_timeout();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Memory (M) stage of the pipelined ARM core.
- Sits between the execute→memory pipeline register and the memory→writeback pipeline register (the WB register).
- Drives a variable-latency data-memory req/ack bus.
- Performs word and byte (LDRB/STRB) lane steering.
- Stalls the upstream pipeline while an access is outstanding, and presents a bubble to the WB register until the access completes.

Parameters:
- TIMEOUT_CYCLES, 255: WAIT-state cycles before an access is abandoned. Used only with the optional feature. Legal range 1..65535.

Ports:
- clk  input  1  clock
- reset  input  1  reset
- PCSrcM  input  1  branch/PC-write from M pipe register
- RegWriteM  input  1  register write enable
- MemtoRegM  input  1  load (result comes from memory)
- MemWriteM  input  1  store
- ByteM  input  1  byte access (1) / word access (0)
- RdM  input  4  destination register
- ALUResultM  input  32  address / ALU result
- WriteDataM  input  32  store data
- PCSrcOut  output  1  to WB register
- RegWriteOut  output  1  to WB register
- MemtoRegOut  output  1  to WB register
- RdOut  output  4  to WB register
- ALUResultOut  output  32  to WB register
- ReadDataM  output  32  load data to WB register
- StallM  output  1  freeze F/D/E/M registers
- dmem_req  output  1  memory request
- dmem_we  output  1  write strobe
- dmem_addr  output  32  word-aligned address ({ALUResultM[31:2],2'b00})
- dmem_be  output  4  byte enables
- dmem_wdata  output  32  store data
- dmem_rdata  input  32  read data, valid with ack
- dmem_ack  input  1  access complete
- mem_fault  output  1  timeout fault, sticky

Behaviour:
- Access condition: access = MemtoRegM | MemWriteM.
- Non-access instructions:
  - Combinational pass-through.
  - StallM=0, ReadDataM=0.
  - Zero added latency.
- FSM states: IDLE, WAIT, DONE.
  - IDLE with access → WAIT (dmem_req rises next cycle).
  - WAIT: dmem_req=1. Address, we, be and wdata are registered and held stable until ack.
  - WAIT with dmem_ack → DONE. Load data is latched on the ack cycle.
  - DONE → IDLE unconditionally.
  - An ack while IDLE or DONE is ignored.
- StallM:
  - 1 in IDLE when access is present.
  - 1 throughout WAIT.
  - 0 in DONE, so the M-stage instruction retires at the end of DONE.
- Bubble: while StallM=1, PCSrcOut, RegWriteOut and MemtoRegOut are forced 0. RdOut and ALUResultOut still pass through.
- Minimum access latency: 3 cycles (IDLE issue, WAIT with ack in the first cycle, DONE).
- Byte enables:
  - Word access: dmem_be=4'b1111, dmem_wdata=WriteDataM.
  - Byte access: dmem_be = one-hot of ALUResultM[1:0] (lane 0 = bits 7:0), dmem_wdata = {4{WriteDataM[7:0]}}.
- Load data:
  - Word load: ReadDataM = latched word.
  - Byte load: ReadDataM = zero-extended selected lane.
  - ReadDataM holds its value through DONE and is 0 otherwise.
- Stores: ReadDataM=0; RegWriteOut follows RegWriteM in DONE.
- Reset (async, any state, including mid-WAIT):
  - State=IDLE.
  - dmem_req=0, dmem_we=0, dmem_be=0, dmem_addr=0, dmem_wdata=0.
  - ReadDataM=0, mem_fault=0.
  - Abandoned requests are the memory's responsibility; a late ack after reset is ignored.
  - Pass-through outputs follow their inputs (zeros from the reset upstream register).

Optional Feature:
- Macro: MEM_TIMEOUT_EN.
- With MEM_TIMEOUT_EN defined:
  - A 16-bit counter clears on entry to WAIT and increments each cycle in WAIT.
  - When the count reaches TIMEOUT_CYCLES without ack: drop dmem_req, go to DONE, ReadDataM=0, RegWriteOut=0 for that instruction.
  - mem_fault is set and stays 1 until reset.
- Without the macro:
  - WAIT persists indefinitely.
  - mem_fault is tied 0 and no counter is built.

Decomposition:
- Shared package:
  - mstate_t enum (IDLE, WAIT, DONE).
  - BE_WORD = 4'b1111 constant.
  - Byte-lane index typedef (2 bits).
- One sub-module: mem_lane_steer, combinational. It generates dmem_be and dmem_wdata, and extracts/zero-extends the load byte.

Test Plan:
- ADD (no access), RegWriteM=1, ALUResultM=0x10 → same-cycle pass-through, StallM=0, no dmem_req.
- Word LDR at 0x100, ack after 2 WAIT cycles, rdata=0xCAFEBABE → StallM high for 3 cycles; bubble outputs during stall; DONE gives ReadDataM=0xCAFEBABE, RegWriteOut=1.
- STRB addr=0x203, WriteDataM=0x12345678 → dmem_be=4'b1000, dmem_wdata=0x78787878, dmem_we=1; DONE with ReadDataM=0.
- LDRB addr=0x41, rdata=0xAABBCCDD → ReadDataM=0x000000CC.
- Reset asserted mid-WAIT, then an ack 1 cycle after release → IDLE, dmem_req=0, ack ignored, no retirement.
- MEM_TIMEOUT_EN with TIMEOUT_CYCLES=4 and no ack → req dropped after 4 WAIT cycles, mem_fault=1 and sticky, RegWriteOut=0 in DONE.
